// File: rtl/sleepy_pkg.sv
// Shared constants, waveform select codes and the noise LFSR step function
// for the sleepy_module oscillator block.
package sleepy_pkg;

    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    // Fibonacci taps; the new LSB is the XOR of these state bits
    localparam int unsigned LFSR_TAP_A = 15;
    localparam int unsigned LFSR_TAP_B = 13;
    localparam int unsigned LFSR_TAP_C = 12;
    localparam int unsigned LFSR_TAP_D = 10;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;
    localparam logic [7:0] MID_SCALE   = 8'h80;

    typedef enum logic [1:0] {
        WAVE_SAW   = 2'b00,
        WAVE_SQR   = 2'b01,
        WAVE_TRI   = 2'b10,
        WAVE_NOISE = 2'b11
    } wave_sel_e;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[LFSR_TAP_A] ^ l[LFSR_TAP_B] ^ l[LFSR_TAP_C] ^ l[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/sleepy_lfsr16.sv
// 16-bit noise LFSR that advances one step whenever step is high.
module sleepy_lfsr16
    import sleepy_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (step) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/sleepy_module.sv
// Low-rate oscillator: phase accumulator feeding a saw/square/triangle/noise
// generator, with a registered 8-bit sample, PWM rendering and a sleep mode.
module sleepy_module
    import sleepy_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED,
    parameter int unsigned PHASE_W   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   phase_sum;
    logic [PHASE_W-1:0] phase_next;
    logic               carry;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_next;
    logic               lfsr_adv;
    logic [7:0]         sample_q;
    logic [7:0]         wave;
    logic               wrap_q;
    logic [7:0]         pwm_cnt;
    logic               sleeping;
    wave_sel_e          sel;
    logic               unused_uio;

    assign sleeping   = uio_in[2] | ~ena;
    assign sel        = wave_sel_e'(uio_in[1:0]);
    assign unused_uio = ^uio_in[7:3];

    assign phase_sum  = {1'b0, phase} + {{(PHASE_W + 1 - 8){1'b0}}, ui_in};
    assign phase_next = phase_sum[PHASE_W-1:0];
    assign carry      = phase_sum[PHASE_W];
    assign lfsr_adv   = carry & ~sleeping;

    sleepy_lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .step (lfsr_adv),
        .state(lfsr)
    );

    // The sample is built from the post-edge LFSR value, so the step is mirrored here
    assign lfsr_next = lfsr_adv ? lfsr_step(lfsr) : lfsr;

    always_comb begin
        wave = MID_SCALE;
        case (sel)
            WAVE_SAW:   wave = phase_next[PHASE_W-1 -: 8];
            WAVE_SQR:   wave = phase_next[PHASE_W-1] ? '1 : '0;
            WAVE_TRI:   wave = phase_next[PHASE_W-1] ? ~phase_next[PHASE_W-2 -: 8]
                                                     :  phase_next[PHASE_W-2 -: 8];
            WAVE_NOISE: wave = lfsr_next[7:0];
            default:    wave = MID_SCALE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            sample_q <= '0;
            wrap_q   <= 1'b0;
        end else if (sleeping) begin
            sample_q <= MID_SCALE;
            wrap_q   <= 1'b0;
        end else begin
            phase    <= phase_next;
            sample_q <= wave;
            wrap_q   <= carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    assign uo_out  = sample_q;
    assign uio_out = {(pwm_cnt < sample_q), sleeping, wrap_q, phase[PHASE_W-1], 4'b0000};
    assign uio_oe  = UIO_OE_MASK;

endmodule

// File: tb/tb_sleepy_module.sv
// Self-checking bench for sleepy_module: directed scenarios plus random
// stimulus, compared against an arithmetic reference model.
module tb_sleepy_module;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    int unsigned m_phase;
    int unsigned m_lfsr;
    int unsigned m_sample;
    int unsigned m_wrap;
    int unsigned m_pwm;

    sleepy_module dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned ref_lfsr(input int unsigned l);
        int unsigned fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 32'hFFFF;
    endfunction

    function automatic int unsigned ref_wave(input int unsigned ph, input int unsigned l,
                                             input int unsigned sel);
        int unsigned tri8 = (ph / 128) % 256;
        case (sel)
            0:       return ph / 256;
            1:       return (ph >= 32768) ? 255 : 0;
            2:       return (ph >= 32768) ? 255 - tri8 : tri8;
            default: return l % 256;
        endcase
    endfunction

    task automatic model_reset();
        m_phase  = 0;
        m_lfsr   = 32'hACE1;
        m_sample = 0;
        m_wrap   = 0;
        m_pwm    = 0;
    endtask

    task automatic model_edge();
        int unsigned tot;
        if (rst_n !== 1'b1) return;
        m_pwm = (m_pwm + 1) % 256;
        if (uio_in[2] || !ena) begin
            m_wrap   = 0;
            m_sample = 128;
        end else begin
            tot     = m_phase + ui_in;
            m_wrap  = (tot >= 65536) ? 1 : 0;
            m_phase = tot % 65536;
            if (m_wrap != 0) m_lfsr = ref_lfsr(m_lfsr);
            m_sample = ref_wave(m_phase, m_lfsr, uio_in[1:0]);
        end
    endtask

    task automatic compare_all(input string tag);
        int unsigned exp_uio;
        exp_uio = ((m_pwm < m_sample) ? 128 : 0)
                | ((uio_in[2] || !ena) ? 64 : 0)
                | ((m_wrap != 0) ? 32 : 0)
                | ((m_phase >= 32768) ? 16 : 0);
        check({tag, ".uo_out"}, {24'd0, uo_out}, m_sample);
        check({tag, ".uio_out"}, {24'd0, uio_out}, exp_uio);
        check({tag, ".uio_oe"}, {24'd0, uio_oe}, 32'hF0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
        check({tag, ".uo_clear"}, {24'd0, uo_out}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int unsigned cnt;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        #12;
        compare_all("reset");
        check("reset.uo_const", {24'd0, uo_out}, 32'h00);
        check("reset.uio_const", {24'd0, uio_out}, 32'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 10; i++) tick("idle");
        check("idle.uo_zero", {24'd0, uo_out}, 32'h00);

        // Saw and wrap pulse
        ui_in = 8'h80;
        tick("saw");
        tick("saw");
        check("saw.two_edges", {24'd0, uo_out}, 32'h01);
        for (int unsigned i = 3; i <= 512; i++) tick("saw");
        check("saw.wrap_pulse", {31'd0, uio_out[5]}, 32'd1);
        check("saw.phase_zero", {24'd0, uo_out}, 32'h00);
        cnt = 0;
        for (int unsigned i = 0; i < 511; i++) begin
            tick("saw");
            cnt += uio_out[5];
        end
        check("saw.wrap_quiet", cnt, 0);

        // Square
        do_reset();
        ui_in  = 8'hFF;
        uio_in = 8'h01;
        for (int unsigned i = 0; i < 128; i++) tick("sqr");
        check("sqr.low_128", {24'd0, uo_out}, 32'h00);
        check("sqr.bit4_low", {31'd0, uio_out[4]}, 32'd0);
        tick("sqr");
        check("sqr.high_129", {24'd0, uo_out}, 32'hFF);
        check("sqr.bit4_high", {31'd0, uio_out[4]}, 32'd1);

        // Triangle
        do_reset();
        uio_in = 8'h02;
        for (int unsigned i = 0; i < 128; i++) tick("tri");
        check("tri.peak", {24'd0, uo_out}, 32'hFF);
        tick("tri");
        tick("tri");
        check("tri.descend", {24'd0, uo_out}, 32'hFD);

        // Noise
        do_reset();
        uio_in = 8'h03;
        tick("noise");
        check("noise.first", {24'd0, uo_out}, 32'hE1);
        for (int unsigned i = 2; i <= 257; i++) tick("noise");
        check("noise.pre_carry", {24'd0, uo_out}, 32'hE1);
        tick("noise");
        check("noise.post_carry", {24'd0, uo_out}, 32'hC3);

        // Sleep via uio_in[2], then via ena
        uio_in = 8'h07;
        tick("sleep");
        check("sleep.mid", {24'd0, uo_out}, 32'h80);
        check("sleep.flag", {31'd0, uio_out[6]}, 32'd1);
        cnt = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            tick("sleep");
            cnt += uio_out[7];
        end
        check("sleep.pwm_half", cnt, 128);
        uio_in = 8'h03;
        for (int unsigned i = 0; i < 20; i++) tick("wake");
        uio_in = 8'h00;
        ui_in  = 8'h37;
        for (int unsigned i = 0; i < 20; i++) tick("saw2");
        ena = 1'b0;
        tick("ena_sleep");
        check("ena_sleep.mid", {24'd0, uo_out}, 32'h80);
        cnt = 0;
        for (int unsigned i = 0; i < 256; i++) begin
            tick("ena_sleep");
            cnt += uio_out[7];
        end
        check("ena_sleep.pwm_half", cnt, 128);
        ena = 1'b1;
        for (int unsigned i = 0; i < 20; i++) tick("ena_wake");

        // Async reset between edges
        async_reset("arst");
        for (int unsigned i = 0; i < 5; i++) tick("post_arst");

        // Random traffic, garbage in the ignored uio_in bits
        for (int unsigned i = 0; i < 3000; i++) begin
            ui_in  = 8'($urandom);
            uio_in = (8'($urandom) & 8'hFB) | ((($urandom % 8) == 0) ? 8'h04 : 8'h00);
            ena    = (($urandom % 16) != 0);
            if (($urandom % 64) == 0) ui_in = 8'h00;
            tick("rand");
            if (($urandom % 500) == 0) async_reset("rand_arst");
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
